// File: rtl/icache_axi_rd_responder.sv
// AXI4 read-channel subordinate for the icache refill path: queues AR requests, waits a fixed
// latency, then streams FIXED/INCR/WRAP bursts out of a backdoor-preloadable word memory.
module icache_axi_rd_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 4096,
  parameter int AR_DEPTH   = 2,
  parameter int LATENCY    = 3,
  localparam int IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [7:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  input  logic                  bd_we,
  input  logic [IDX_W-1:0]      bd_idx,
  input  logic [DATA_WIDTH-1:0] bd_wdata
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPB);
  localparam int PTR_W = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
  localparam int CNT_W = $clog2(AR_DEPTH + 1);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int EW    = ADDR_WIDTH + ID_WIDTH + 8 + 2 + 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

  // ---------------- AR request queue ----------------
  logic [EW-1:0]    q_mem [AR_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push, pop;
  logic [EW-1:0]    ar_entry, head;

  state_t state_reg, state_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(AR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign ar_ready = !rst && (count_reg < CNT_W'(AR_DEPTH));
  assign push     = ar_valid && ar_ready;
  assign pop      = (state_reg == ST_IDLE) && (count_reg != '0);
  // size legality is folded into one bit at enqueue so the queue need not carry ar_size
  assign ar_entry = {ar_addr, ar_id, ar_len, ar_burst, (ar_size != 3'(OFF_W))};
  assign head     = q_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_reg] <= ar_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] head_addr, head_base;
  logic [ID_WIDTH-1:0]   head_id;
  logic [7:0]            head_len;
  logic [1:0]            head_burst;
  logic                  head_size_err, head_err, wrap_len_ok;

  assign {head_addr, head_id, head_len, head_burst, head_size_err} = head;
  assign head_base   = head_addr & ~ADDR_WIDTH'(BPB - 1);
  assign wrap_len_ok = (head_len == 8'd1) || (head_len == 8'd3) ||
                       (head_len == 8'd7) || (head_len == 8'd15);
  assign head_err    = head_size_err || (head_burst == BURST_RSVD) ||
                       ((head_burst == BURST_WRAP) && !wrap_len_ok);

  // ---------------- burst engine ----------------
  logic [LAT_W-1:0]      lat_cnt_reg;
  logic [7:0]            beat_cnt_reg, len_reg;
  logic [1:0]            burst_reg, resp_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic                  err_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic                  beat_last, load_beat, beat_err;
  logic [ADDR_WIDTH-1:0] rd_addr, next_addr, incr_addr, wrap_size, wrap_mask, rd_word;
  logic [IDX_W-1:0]      rd_idx;

  assign beat_last = (beat_cnt_reg == len_reg);
  assign incr_addr = addr_reg + ADDR_WIDTH'(BPB);
  assign wrap_size = ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1);
  assign wrap_mask = (wrap_size << OFF_W) - ADDR_WIDTH'(1);

  always_comb begin
    case (burst_reg)
      BURST_FIXED: next_addr = addr_reg;
      BURST_WRAP:  next_addr = (addr_reg & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  // load_beat fetches the word for the beat presented next cycle, so r_data is registered
  always_comb begin
    state_next = state_reg;
    load_beat  = 1'b0;
    rd_addr    = next_addr;
    case (state_reg)
      ST_IDLE: begin
        if (pop) begin
          if (LATENCY > 0) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_BURST;
            load_beat  = 1'b1;
            rd_addr    = head_base;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt_reg == LAT_W'(LATENCY - 1)) begin
          state_next = ST_BURST;
          load_beat  = 1'b1;
          rd_addr    = addr_reg;
        end
      end
      ST_BURST: begin
        if (r_ready) begin
          if (beat_last) state_next = ST_IDLE;
          else           load_beat  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_word  = rd_addr >> OFF_W;
  assign rd_idx   = rd_word[IDX_W-1:0];
  assign beat_err = ((state_reg == ST_IDLE) ? head_err : err_reg) ||
                    (rd_word >= ADDR_WIDTH'(MEM_WORDS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lat_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
      len_reg      <= '0;
      burst_reg    <= '0;
      id_reg       <= '0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      resp_reg     <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        addr_reg     <= head_base;
        id_reg       <= head_id;
        len_reg      <= head_len;
        burst_reg    <= head_burst;
        err_reg      <= head_err;
        lat_cnt_reg  <= '0;
        beat_cnt_reg <= '0;
      end
      if (state_reg == ST_WAIT) lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
      if (load_beat) begin
        addr_reg <= rd_addr;
        resp_reg <= beat_err ? RESP_SLVERR : RESP_OKAY;
      end
      if ((state_reg == ST_BURST) && r_ready && !beat_last)
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
    end
  end

  // ---------------- word memory (not cleared by reset) ----------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (bd_we && ({1'b0, bd_idx} < (IDX_W + 1)'(MEM_WORDS))) mem[bd_idx] <= bd_wdata;
    if (load_beat) rd_data_reg <= mem[rd_idx];
  end

  assign r_valid = (state_reg == ST_BURST);
  assign r_last  = r_valid && beat_last;
  assign r_id    = id_reg;
  assign r_resp  = r_valid ? resp_reg : RESP_OKAY;
  assign r_data  = (r_valid && (resp_reg == RESP_OKAY)) ? rd_data_reg : '0;

endmodule

// File: tb/tb_icache_axi_rd_responder.sv
// Scoreboard bench for icache_axi_rd_responder: expected beats are queued as ARs are issued
// and compared as R beats are accepted.
module tb_icache_axi_rd_responder;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MW  = 4096;
  localparam int ARD = 2;
  localparam int LAT = 3;
  localparam int XW  = $clog2(MW);

  logic          clk = 1'b0;
  logic          rst;
  logic          ar_valid, ar_ready;
  logic [AW-1:0] ar_addr;
  logic [IW-1:0] ar_id;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic          r_valid, r_ready, r_last;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic [1:0]    r_resp;
  logic          bd_we;
  logic [XW-1:0] bd_idx;
  logic [DW-1:0] bd_wdata;

  icache_axi_rd_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .MEM_WORDS(MW), .AR_DEPTH(ARD), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last),
    .bd_we(bd_we), .bd_idx(bd_idx), .bd_wdata(bd_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] tb_mem [MW];
  int            n_checks  = 0;
  int            n_errors  = 0;
  int            mon_beats = 0;
  int            rdy_mode  = 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [1:0] burst, input int k);
    logic [31:0] a, c, low;
    a = addr & ~32'd7;
    case (burst)
      2'b00: return a;
      2'b10: begin
        c   = (32'(len) + 1) * 8;
        low = a & ~(c - 1);
        return low + ((a - low + 32'(k) * 8) % c);
      end
      default: return a + 32'(k) * 8;
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    logic        err_all, bad;
    logic [31:0] a, idx;
    beat_t       e;
    err_all = (burst == 2'b11) || (size != 3'd3) ||
              ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    for (int k = 0; k <= int'(len); k++) begin
      a      = model_addr(addr, len, burst, k);
      idx    = a >> 3;
      bad    = err_all || (idx >= MW);
      e.data = bad ? '0 : tb_mem[idx[XW-1:0]];
      e.resp = bad ? 2'b10 : 2'b00;
      e.id   = id;
      e.last = (k == int'(len));
      sb.push_back(e);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    ar_addr = addr; ar_id = id; ar_len = len; ar_burst = burst; ar_size = size;
    ar_valid = 1'b1;
    @(negedge clk);
    while (!ar_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ar_ready) begin
      check_val("ar_accept_timeout", ar_ready, 1'b1);
      @(posedge clk); #1 ar_valid = 1'b0;
      return;
    end
    push_exp(addr, id, len, burst, size);
    @(posedge clk); #1 ar_valid = 1'b0;
  endtask

  task automatic bd_write(input int idx, input logic [DW-1:0] data);
    bd_we = 1'b1; bd_idx = XW'(idx); bd_wdata = data;
    tb_mem[idx] = data;
    @(posedge clk); #1 bd_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_remaining", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // r_ready: 0 = hold low, 1 = hold high, 2 = random
  initial begin
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       r_ready = 1'b0;
        1:       r_ready = 1'b1;
        default: r_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare accepted beats against the scoreboard; check stability while stalled.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic [IW-1:0] stall_id;
  logic          stall_last;
  beat_t         mon_e;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else if (r_valid) begin
      if (stall_q) begin
        check_val("stall_data", r_data, stall_data);
        check_val("stall_id", 64'(r_id), 64'(stall_id));
        check_val("stall_last", 64'(r_last), 64'(stall_last));
      end
      if (r_ready) begin
        stall_q = 1'b0;
        if (sb.size() == 0) begin
          check_val("unexpected_beat", 64'(r_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_val("r_data", r_data, mon_e.data);
          check_val("r_id", 64'(r_id), 64'(mon_e.id));
          check_val("r_resp", 64'(r_resp), 64'(mon_e.resp));
          check_val("r_last", 64'(r_last), 64'(mon_e.last));
          mon_beats++;
          if (mon_e.last) $display("burst done: id=%0d resp=%0d t=%0t", r_id, r_resp, $time);
        end
      end else begin
        stall_q    = 1'b1;
        stall_data = r_data;
        stall_id   = r_id;
        stall_last = r_last;
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    logic [31:0] addr;
    rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0; ar_size = 3'd3;
    ar_burst = 2'b01; bd_we = 1'b0; bd_idx = '0; bd_wdata = '0;
    rdy_mode = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_r_valid", 64'(r_valid), 64'd0);
    check_val("rst_r_last", 64'(r_last), 64'd0);
    check_val("rst_r_resp", 64'(r_resp), 64'd0);
    check_val("rst_r_id", 64'(r_id), 64'd0);
    check_val("rst_r_data", r_data, 64'd0);
    check_val("rst_ar_ready", 64'(ar_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("ar_ready_after_rst", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;

    // Preload: mem[0..7] = i, rest random
    for (int i = 0; i < MW; i++)
      bd_write(i, (i < 8) ? 64'(i) : {$urandom, $urandom});

    // 1: INCR len 7 from 0, latency to first beat
    send_ar(32'h0, 4'd5, 8'd7, 2'b01, 3'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r_valid && n < 50);
    check_val("first_beat_latency", 64'(n), 64'(LAT + 2));
    @(posedge clk); #1;
    drain();

    // 2: WRAP len 3 at 0x28, WRAP len 2 (illegal), bad size
    send_ar(32'h28, 4'd1, 8'd3, 2'b10, 3'd3);
    send_ar(32'h28, 4'd2, 8'd2, 2'b10, 3'd3);
    send_ar(32'h40, 4'd3, 8'd1, 2'b01, 3'd2);
    drain();

    // 4: run off the end of memory, reserved burst type
    send_ar(32'((MW - 2) * 8), 4'd4, 8'd3, 2'b01, 3'd3);
    send_ar(32'h100, 4'd6, 8'd2, 2'b11, 3'd3);
    drain();

    // 3: back-to-back ARs with R stalled; queue fills
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_ar(32'h200, 4'd7, 8'd3, 2'b01, 3'd3);
    send_ar(32'h300, 4'd8, 8'd1, 2'b01, 3'd3);
    send_ar(32'h400, 4'd9, 8'd0, 2'b00, 3'd3);
    @(negedge clk);
    check_val("ar_ready_full", 64'(ar_ready), 64'd0);
    repeat (10) @(negedge clk);
    check_val("stalled_r_valid", 64'(r_valid), 64'd1);
    check_val("ar_ready_still_full", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 1;
    drain();

    // 5: random INCR/FIXED bursts under random r_ready
    rdy_mode = 2;
    for (int t = 0; t < 200; t++) begin
      addr = 32'($urandom_range(0, MW - 17)) * 8 + 32'($urandom_range(0, 7));
      send_ar(addr, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01, 3'd3);
    end
    drain();

    // 6: reset during beat 3 of an 8-beat burst with another AR queued
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    base = mon_beats;
    send_ar(32'h80, 4'd10, 8'd7, 2'b01, 3'd3);
    send_ar(32'h180, 4'd11, 8'd3, 2'b01, 3'd3);
    n = 0;
    while (mon_beats < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_val("beats_before_rst", 64'(mon_beats), 64'(base + 2));
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_val("rst_mid_r_valid", 64'(r_valid), 64'd0);
    check_val("rst_mid_r_last", 64'(r_last), 64'd0);
    check_val("rst_mid_ar_ready", 64'(ar_ready), 64'd1);
    repeat (12) @(posedge clk);
    #1;
    check_val("no_beats_after_rst", 64'(mon_beats), 64'(base + 2));
    send_ar(32'h10, 4'd12, 8'd1, 2'b01, 3'd3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
